// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS token constants, aligner state type and symbol decode
// Contents: TOKEN_CTRL0..3 control-token symbols, align_state_t, tmds_decode_word().
package tmds_pkg;

  localparam logic [9:0] TOKEN_CTRL0 = 10'h354;  // {c1,c0} = 00
  localparam logic [9:0] TOKEN_CTRL1 = 10'h0AB;  // {c1,c0} = 01
  localparam logic [9:0] TOKEN_CTRL2 = 10'h154;  // {c1,c0} = 10
  localparam logic [9:0] TOKEN_CTRL3 = 10'h2AB;  // {c1,c0} = 11

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

  // Undo the TMDS data-period encoding: bit 9 flags inversion of the low byte,
  // bit 8 selects XOR (1) or XNOR (0) chaining between neighbouring bits.
  function automatic logic [7:0] tmds_decode_word(input logic [9:0] sym);
    logic [7:0] d;
    logic [7:0] q;
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// rtl/tmds_word_aligner.sv - word alignment, control-token match and lock FSM for one channel
// Ports: clk, reset (sync, active-high); raw_bits/raw_valid deserializer words;
//   word/word_valid/word_token/word_ctrl stage-1 aligned symbol; locked; slip_offset (0..9).
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw_bits,
  input  logic       raw_valid,
  output logic [9:0] word,
  output logic       word_valid,
  output logic       word_token,
  output logic [1:0] word_ctrl,
  output logic       locked,
  output logic [3:0] slip_offset
);

  localparam int IDLE_MAX = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
  localparam int RUN_W    = $clog2(CTRL_RUN) + 1;
  localparam int IDLE_W   = $clog2(IDLE_MAX) + 1;
  localparam logic [RUN_W-1:0]  RUN_LAST    = RUN_W'(CTRL_RUN);
  localparam logic [IDLE_W-1:0] SEARCH_LAST = IDLE_W'(SEARCH_TIMEOUT);
  localparam logic [IDLE_W-1:0] LOCK_LAST   = IDLE_W'(LOCK_TIMEOUT);

  logic [9:0]        prev;
  logic [19:0]       window_shifted;
  logic [9:0]        aligned;
  logic              aligned_token;
  logic [1:0]        aligned_ctrl;

  align_state_t      state, state_next;
  logic [RUN_W-1:0]  run, run_next, run_inc;
  logic [IDLE_W-1:0] idle_cnt, idle_next, idle_inc;
  logic [3:0]        offset_next;

  // The previous word holds the earlier bits, so offset k picks stream bits k..k+9.
  assign window_shifted = {raw_bits, prev} >> slip_offset;
  assign aligned        = window_shifted[9:0];

  always_comb begin
    aligned_token = 1'b1;
    aligned_ctrl  = 2'b00;
    case (aligned)
      TOKEN_CTRL0: aligned_ctrl = 2'b00;
      TOKEN_CTRL1: aligned_ctrl = 2'b01;
      TOKEN_CTRL2: aligned_ctrl = 2'b10;
      TOKEN_CTRL3: aligned_ctrl = 2'b11;
      default:     aligned_token = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      word_token <= 1'b0;
      word_ctrl  <= 2'b00;
    end else begin
      word_valid <= raw_valid;
      if (raw_valid) begin
        prev       <= raw_bits;
        word       <= aligned;
        word_token <= aligned_token;
        word_ctrl  <= aligned_ctrl;
      end
    end
  end

  // The FSM acts on the stage-1 word so locked changes on the same edge as the
  // decoded output of the word that caused it.
  assign run_inc  = run + RUN_W'(1);
  assign idle_inc = idle_cnt + IDLE_W'(1);

  always_comb begin
    state_next  = state;
    run_next    = run;
    idle_next   = idle_cnt;
    offset_next = slip_offset;
    if (word_valid) begin
      case (state)
        SEARCH: begin
          if (word_token) begin
            idle_next = '0;
            run_next  = run_inc;
            if (run_inc == RUN_LAST) state_next = LOCKED;
          end else begin
            run_next = '0;
            if (idle_inc == SEARCH_LAST) begin
              idle_next   = '0;
              offset_next = (slip_offset == 4'd9) ? 4'd0 : slip_offset + 4'd1;
            end else begin
              idle_next = idle_inc;
            end
          end
        end
        LOCKED: begin
          if (word_token) begin
            idle_next = '0;
          end else if (idle_inc == LOCK_LAST) begin
            state_next = SEARCH;
            run_next   = '0;
            idle_next  = '0;
          end else begin
            idle_next = idle_inc;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      run         <= '0;
      idle_cnt    <= '0;
      slip_offset <= 4'd0;
    end else begin
      state       <= state_next;
      run         <= run_next;
      idle_cnt    <= idle_next;
      slip_offset <= offset_next;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - one TMDS receive channel: align, token detect, decode
// Ports: clk, reset (sync, active-high); raw_bits/raw_valid deserializer words;
//   data_out, ctrl_out, de, out_valid decoded symbol; locked; slip_offset (0..9).
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw_bits,
  input  logic       raw_valid,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de,
  output logic       out_valid,
  output logic       locked,
  output logic [3:0] slip_offset
);

  logic [9:0] word;
  logic       word_valid;
  logic       word_token;
  logic [1:0] word_ctrl;

  tmds_word_aligner #(
    .CTRL_RUN       (CTRL_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT)
  ) u_aligner (
    .clk         (clk),
    .reset       (reset),
    .raw_bits    (raw_bits),
    .raw_valid   (raw_valid),
    .word        (word),
    .word_valid  (word_valid),
    .word_token  (word_token),
    .word_ctrl   (word_ctrl),
    .locked      (locked),
    .slip_offset (slip_offset)
  );

  // Tokens update only ctrl_out and data words only data_out, so each output
  // keeps its last value through the other kind of period.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= 8'h00;
      ctrl_out  <= 2'b00;
      de        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= word_valid;
      if (word_valid) begin
        if (word_token) begin
          de       <= 1'b0;
          ctrl_out <= word_ctrl;
        end else begin
          de       <= 1'b1;
          data_out <= tmds_decode_word(word);
        end
      end
    end
  end

endmodule
